// File: rtl/mul_iter_radix.sv
// Iterative shift-add multiplier retiring RADIX_BITS multiplier bits per cycle (s*s, s*u, u*u, RV64 word mode).
// Optional build macro MUL_EARLY_EXIT_EN ends CALC as soon as the remaining multiplier bits are zero.
module mul_iter_radix #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [1:0]      mul_signed,
  input  logic            mulw,
  input  logic [XLEN-1:0] mul1,
  input  logic [XLEN-1:0] mul2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_h,
  output logic [XLEN-1:0] result_l
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CntW  = $clog2(XLEN);
  localparam int unsigned NFull = XLEN / RADIX_BITS;
  localparam int unsigned NWord = 32 / RADIX_BITS;
  localparam logic [XLEN-1:0] WordMask = XLEN'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [PW-1:0]   r_mcand, r_acc;
  logic [XLEN-1:0] r_mplier;
  logic            r_neg, r_word;
  logic [XLEN-1:0] r_res_h, r_res_l;

  logic            w_accept, w_sign_a, w_sign_b, w_calc_last;
  logic [XLEN-1:0] w_mask, w_op_a, w_op_b, w_mag_a, w_mag_b, w_mplier_nxt;
  logic [PW-1:0]   w_pp, w_acc_nxt, w_prod;

  assign w_accept  = mul_valid && (r_state == StIdle) && !flush;
  assign mul_ready = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result_h  = r_res_h;
  assign result_l  = r_res_l;

  // Operand magnitudes; in word mode the mask after negation keeps |-2^31| = 2^31 exact.
  always_comb begin
    w_mask   = mulw ? WordMask : '1;
    w_sign_a = mul_signed[1] & (mulw ? mul1[31] : mul1[XLEN-1]);
    w_sign_b = (&mul_signed) & (mulw ? mul2[31] : mul2[XLEN-1]);
    w_op_a   = mul1 & w_mask;
    w_op_b   = mul2 & w_mask;
    w_mag_a  = (w_sign_a ? (~w_op_a + XLEN'(1)) : w_op_a) & w_mask;
    w_mag_b  = (w_sign_b ? (~w_op_b + XLEN'(1)) : w_op_b) & w_mask;
  end

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
    w_acc_nxt    = r_acc + w_pp;
    w_mplier_nxt = r_mplier >> RADIX_BITS;
    w_prod       = r_neg ? (~r_acc + PW'(1)) : r_acc;
  end

`ifdef MUL_EARLY_EXIT_EN
  assign w_calc_last = (r_cnt == '0) || (w_mplier_nxt == '0);
`else
  assign w_calc_last = (r_cnt == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (mul_valid) w_state_nxt = StCalc;
        StCalc:  if (w_calc_last) w_state_nxt = StFix;
        StFix:   w_state_nxt = StDone;
        StDone:  if (out_ready) w_state_nxt = StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_word   <= 1'b0;
      r_res_h  <= '0;
      r_res_l  <= '0;
    end else if (w_accept) begin
      r_cnt    <= mulw ? CntW'(NWord - 1) : CntW'(NFull - 1);
      r_mcand  <= PW'(w_mag_a);
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_neg    <= w_sign_a ^ w_sign_b;
      r_word   <= mulw;
    end else if (r_state == StCalc) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << RADIX_BITS;
      r_mplier <= w_mplier_nxt;
      if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
    end else if (r_state == StFix && !flush) begin
      if (r_word) begin
        r_res_h <= '0;
        r_res_l <= XLEN'($signed(w_prod[31:0]));
      end else begin
        r_res_h <= w_prod[PW-1:XLEN];
        r_res_l <= w_prod[XLEN-1:0];
      end
    end
  end

endmodule

// File: doc/mul_iter_radix.md
Name: mul_iter_radix

Overview:
- Parametrised iterative shift-add multiplier; successor to the fixed 64-bit, 1-bit-per-two-cycles multiplier in the execute stage.
- Retires RADIX_BITS multiplier bits per cycle and supports signed×signed, signed×unsigned and unsigned×unsigned operation.
- Supports RV64 word mode, flush and output back-pressure.
- Sits beside the ALU in EXU; issues mul/mulh/mulhsu/mulhu/mulw results to the writeback mux.

Parameters:
- XLEN, 64: operand width; must be 32 or 64.
- RADIX_BITS, 2: multiplier bits consumed per CALC cycle; must be 1, 2 or 4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  abort current operation.
- mul_valid  in  1  request valid.
- mul_ready  out  1  block idle; request accepted when mul_valid && mul_ready.
- mul_signed  in  2  2'b11 s×s, 2'b10 s(mul1)×u(mul2), 2'b00 u×u, 2'b01 treated as u×u.
- mulw  in  1  32-bit word mode.
- mul1  in  XLEN  multiplicand.
- mul2  in  XLEN  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result_h  out  XLEN  high half of product.
- result_l  out  XLEN  low half of product.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, all datapath registers 0.
  - mul_ready=1, out_valid=0, result_h=result_l=0.
- States: IDLE, CALC, FIX, DONE. mul_ready=(state==IDLE); out_valid=(state==DONE).
- IDLE, on accept:
  - Latch |mul1| and |mul2| as magnitudes (2's complement negate when the operand is signed and negative).
  - Signed-ness of each operand follows mul_signed.
  - In word mode, bit 31 is the sign bit and only bits [31:0] are used; upper bits are ignored.
  - Latch neg = signA ^ signB.
  - Clear accumulator (2*XLEN bits).
  - counter = N-1, where N = W/RADIX_BITS and W = mulw ? 32 : XLEN.
  - Go to CALC.
- CALC, each cycle:
  - acc += mcand * mplier[RADIX_BITS-1:0], with mcand 2*XLEN wide.
  - mcand <<= RADIX_BITS; mplier >>= RADIX_BITS.
  - At counter==0, go to FIX; else counter--.
- FIX: product = neg ? (~acc+1) : acc, computed over the full 2*XLEN width and registered. Go to DONE.
- DONE:
  - Full mode: result_h = product[2*XLEN-1:XLEN], result_l = product[XLEN-1:0].
  - Word mode: result_l = sign-extension of product[31:0], result_h = 0.
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE next edge.
  - Zero-bubble back-to-back is not required: the next request is accepted in IDLE.
- Latency: accept edge t0; out_valid high after edge t0+N+1.
  - XLEN=64, RADIX_BITS=2: 33 cycles full, 17 cycles word.
- flush:
  - In any state, next state is IDLE and out_valid drops at the next edge.
  - A mul_valid in the same cycle as flush is not accepted.
  - mul_ready stays 1 in IDLE during flush.
- Result registers change only in FIX; outside DONE their values are don't-care to consumers.
- mul_valid while busy is ignored (no queueing); inputs are sampled only on the accept edge.
- Most-negative operands: magnitude 2^(W-1) fits unsigned in W bits; the product must still be exact (e.g. -2^63 × -2^63 = 2^126).

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in CALC, if the remaining multiplier register (after the current shift) is 0, go to FIX immediately regardless of counter.
  - Latency becomes ceil(msb_index(|mul2|)+1 / RADIX_BITS)+1 cycles, minimum 2 (mul2=0 or 1).
- Undefined: fixed latency N+1; results identical in both builds.

Test Plan:
- Full u×u, mul1=64'hFFFF_FFFF_FFFF_FFFF, mul2=2 -> result_h=1, result_l=64'hFFFF_FFFF_FFFF_FFFE; out_valid exactly 33 cycles after accept (no MUL_EARLY_EXIT_EN).
- s×s, mul1=-3, mul2=7 -> result_h=64'hFFFF_FFFF_FFFF_FFFF, result_l=-21. s×u, mul1=-1, mul2=64'hFFFF_FFFF_FFFF_FFFF -> result_h=64'hFFFF_FFFF_FFFF_FFFF, result_l=1.
- mulw s×s, mul1=64'h1234_5678_8000_0000, mul2=2 -> result_l=64'h0 (sext of 32'h0000_0000), result_h=0, latency 17. mul1=32'h4000_0000, mul2=2 -> result_l=64'hFFFF_FFFF_8000_0000.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and results stable, mul_ready=0; raise out_ready -> IDLE next cycle, mul_ready=1.
- flush at CALC cycle 5, with mul_valid asserted the same cycle -> no out_valid for that op, state IDLE next cycle; the following request 5×6 returns result_l=30.
- Async reset asserted mid-CALC, without a clock edge -> mul_ready=1, out_valid=0 immediately. With MUL_EARLY_EXIT_EN: mul2=1 -> out_valid 2 cycles after accept.
